interrupt_ctrl: RTL



---
 rtl/interrupt_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/interrupt_ctrl.sv
// Prioritising interrupt front-end for the 5-stage MIPS datapath: synchronises request
// lines, latches rising edges as pending, and hands one line at a time to the controller.
module interrupt_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               status,
  input  logic               epc_wen,
  output logic               interrupter,
  output logic [2:0]         interrupter_no,
  output logic               valid_interrupter,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_SET   = 2'd2,
    IN_HANDLER = 2'd3
  } state_e;

  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [NUM_IRQ-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]       sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0]       prev_q, prev_d;
  logic [NUM_IRQ-1:0]       armed_q, armed_d;
  logic [SYNC_STAGES-1:0]   settle_q, settle_d;
  logic [NUM_IRQ-1:0]       pending_q, pending_d;
  logic                     valid_q, valid_d;
  logic [2:0]               irq_no_q, irq_no_d;
  logic [3:0]               cnt_q, cnt_d;

  logic [NUM_IRQ-1:0]       sync_out;
  logic [NUM_IRQ-1:0]       rise;
  logic [NUM_IRQ-1:0]       cand;
  logic [NUM_IRQ-1:0]       clr;
  logic [2:0]               pri;
  logic                     ack_take;
  logic                     settled;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SYNC_STAGES-1];
  assign cand     = pending_q & irq_mask;
  assign ack_take = (state_q == REQ) && epc_wen;

  // A line only becomes armed once the synchroniser holds real samples and shows it low,
  // so a line already high at reset release needs a fresh low-to-high transition.
  always_comb begin
    sync_d[0] = irq_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d   = sync_out;
    settle_d = (settle_q << 1) | SYNC_STAGES'(1);
    armed_d  = armed_q | ({NUM_IRQ{settled}} & ~sync_out);
    rise     = sync_out & ~prev_q & armed_q;
  end

  always_comb begin
    pri = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pri = 3'(i);
      end
    end
  end

  always_comb begin
    clr = '0;
    if (ack_take) begin
      clr[irq_no_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | rise;
    valid_d   = |cand;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!status && (cand != '0)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (epc_wen) begin
          state_d = WAIT_SET;
        end else if (!irq_mask[irq_no_q] || status) begin
          state_d = IDLE;
        end
      end
      WAIT_SET: begin
        if (status) begin
          state_d = IN_HANDLER;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
        end
      end
      IN_HANDLER: begin
        if (!status) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line number is captured only when a request is launched and then held through
  // the acknowledge and the handler so the cause read sees the serviced line.
  always_comb begin
    irq_no_d = irq_no_q;
    cnt_d    = cnt_q;
    if ((state_q == IDLE) && (state_d == REQ)) begin
      irq_no_d = pri;
    end
    if (ack_take) begin
      cnt_d = 4'd0;
    end else if (state_q == WAIT_SET) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    interrupter       = (state_q == REQ);
    interrupter_no    = irq_no_q;
    valid_interrupter = valid_q;
    pending           = pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q    <= '0;
      armed_q   <= '0;
      settle_q  <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      irq_no_q  <= '0;
      cnt_q     <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q    <= prev_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      irq_no_q  <= irq_no_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
